// File: rtl/tmr_result_voter.sv
// Triple-modular-redundancy result voter: bitwise 2-of-3 vote of three ALU lanes into a one-deep output register.
// Optional per-lane fault counters are built only when FAULT_CNT_EN is defined.
module tmr_result_voter (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        DataReady,
    input  logic [2:0]  OPCODE,
    input  logic [15:0] IN_ALU_1,
    input  logic [15:0] IN_ALU_2,
    input  logic [15:0] IN_ALU_3,
    input  logic [14:0] IN_ALU_MUL_1,
    input  logic [14:0] IN_ALU_MUL_2,
    input  logic [14:0] IN_ALU_MUL_3,
    input  logic        IN_COUT_1,
    input  logic        IN_COUT_2,
    input  logic        IN_COUT_3,
    output logic        IN_READY,
    input  logic        OUT_READY,
    output logic        OUT_VALID,
    output logic [15:0] OUT_RESULT,
    output logic [14:0] OUT_RESULT_MUL,
    output logic        OUT_COUT,
    output logic [2:0]  OUT_OPCODE,
    output logic [2:0]  FAULT_LANE,
    output logic        FAULT_UNCORR,
    input  logic        CLR_CNT
`ifdef FAULT_CNT_EN
    ,
    output logic [7:0]  FAULT_CNT_1,
    output logic [7:0]  FAULT_CNT_2,
    output logic [7:0]  FAULT_CNT_3
`endif
);

    localparam logic [2:0] OP_MUL = 3'b010;
    localparam int         WORD_W = 32;   // {cout, mul[14:0], alu[15:0]}

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   accept;

    // ------------------------------------------------------------------
    // Handshake: one-deep register that can refill while draining.
    // ------------------------------------------------------------------
    assign IN_READY  = (state_q == EMPTY) || OUT_READY;
    assign accept    = DataReady && IN_READY;
    assign OUT_VALID = (state_q == FULL);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (!accept && OUT_READY) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (!RST_N) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // Voting. MUL lanes are forced to zero outside multiply so they vote
    // to zero and can never register as a fault.
    // ------------------------------------------------------------------
    logic              is_mul;
    logic [14:0]       mul_1, mul_2, mul_3;
    logic [WORD_W-1:0] word_1, word_2, word_3;
    logic [WORD_W-1:0] voted;
    logic [2:0]        fault_d;
    logic              uncorr_d;

    assign is_mul = (OPCODE == OP_MUL);
    assign mul_1  = is_mul ? IN_ALU_MUL_1 : 15'h0000;
    assign mul_2  = is_mul ? IN_ALU_MUL_2 : 15'h0000;
    assign mul_3  = is_mul ? IN_ALU_MUL_3 : 15'h0000;

    assign word_1 = {IN_COUT_1, mul_1, IN_ALU_1};
    assign word_2 = {IN_COUT_2, mul_2, IN_ALU_2};
    assign word_3 = {IN_COUT_3, mul_3, IN_ALU_3};

    assign voted  = (word_1 & word_2) | (word_1 & word_3) | (word_2 & word_3);

    assign fault_d[0] = |(word_1 ^ voted);
    assign fault_d[1] = |(word_2 ^ voted);
    assign fault_d[2] = |(word_3 ^ voted);

    // Two or more disagreeing lanes means no pair of lanes matched as a whole word.
    assign uncorr_d = (fault_d[0] & fault_d[1]) | (fault_d[0] & fault_d[2]) | (fault_d[1] & fault_d[2]);

    // ------------------------------------------------------------------
    // Output register: loads only on accept, otherwise holds.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        // NOTE: the result registers are cleared by reset as well, so a discarded result never lingers on the bus.
        if (!RST_N) begin
            OUT_RESULT     <= '0;
            OUT_RESULT_MUL <= '0;
            OUT_COUT       <= 1'b0;
            OUT_OPCODE     <= '0;
            FAULT_LANE     <= '0;
            FAULT_UNCORR   <= 1'b0;
        end else if (accept) begin
            OUT_RESULT     <= voted[15:0];
            OUT_RESULT_MUL <= voted[30:16];
            OUT_COUT       <= voted[31];
            OUT_OPCODE     <= OPCODE;
            FAULT_LANE     <= fault_d;
            FAULT_UNCORR   <= uncorr_d;
        end
    end

`ifdef FAULT_CNT_EN
    // ------------------------------------------------------------------
    // Saturating per-lane fault counters; clear beats increment.
    // ------------------------------------------------------------------
    logic [7:0] fault_cnt [3];

    always_ff @(posedge CLK) begin
        for (int i = 0; i < 3; i++) begin
            if (!RST_N || CLR_CNT) begin
                fault_cnt[i] <= 8'h00;
            end else if (accept && fault_d[i] && (fault_cnt[i] != 8'hFF)) begin
                fault_cnt[i] <= fault_cnt[i] + 8'd1;
            end
        end
    end

    assign FAULT_CNT_1 = fault_cnt[0];
    assign FAULT_CNT_2 = fault_cnt[1];
    assign FAULT_CNT_3 = fault_cnt[2];
`else
    // Counter clear has nothing to act on in this build.
    logic unused_clr_cnt;
    assign unused_clr_cnt = CLR_CNT;
`endif

endmodule

// File: doc/tmr_result_voter.md
TMR_RESULT_VOTER -- requirements
Module: tmr_result_voter

Interface
REQ-001 CLK  input  1  single clock; all state updates on rising edge.
REQ-002 RST_N  input  1  reset, synchronous, active-low.
REQ-003 DataReady  input  1  the three ALU lanes present a valid result this cycle.
REQ-004 OPCODE  input  3  opcode driven to all three lanes (000 add, 001 sub, 010 mul, 011-111 logic/shift).
REQ-005 IN_ALU_1/2/3  input  16 each  lane result low word.
REQ-006 IN_ALU_MUL_1/2/3  input  15 each  lane product high bits; meaningful only when OPCODE=010.
REQ-007 IN_COUT_1/2/3  input  1 each  lane carry.
REQ-008 IN_READY  output  1  block can accept a result this cycle.
REQ-009 OUT_READY  input  1  consumer accepts the held result.
REQ-010 OUT_VALID  output  1  held result valid.
REQ-011 OUT_RESULT  output  16  voted low word.
REQ-012 OUT_RESULT_MUL  output  15  voted high bits.
REQ-013 OUT_COUT  output  1  voted carry.
REQ-014 OUT_OPCODE  output  3  opcode captured with the result.
REQ-015 FAULT_LANE  output  3  bit i-1 set when lane i disagreed with the voted result.
REQ-016 FAULT_UNCORR  output  1  two or more FAULT_LANE bits set.
REQ-017 CLR_CNT  input  1  synchronous clear of the fault counters.
REQ-018 FAULT_CNT_1/2/3  output  8 each  per-lane fault counters; present only with FAULT_CNT_EN.

Function
REQ-019 The block SHALL have two states: EMPTY (OUT_VALID=0) and FULL (OUT_VALID=1).
REQ-020 IN_READY SHALL be combinational: (state==EMPTY) OR OUT_READY.
REQ-021 The block SHALL accept a result when DataReady AND IN_READY. On accept, the state SHALL become FULL and the output registers SHALL load on that edge, giving 1-cycle latency.
REQ-022 In FULL, when OUT_READY=1 and no accept occurs, the state SHALL become EMPTY. When OUT_READY=1 and an accept occurs in the same cycle, the state SHALL stay FULL with the new data, giving full throughput.
REQ-023 In FULL with OUT_READY=0, all outputs SHALL hold unchanged and input is not accepted.
REQ-024 When DataReady=0, the block SHALL ignore lane inputs entirely, because the lanes drive high-impedance then.
REQ-025 Every output bit SHALL be the bitwise 2-of-3 majority of the corresponding lane bits: (a&b)|(a&c)|(b&c).
REQ-026 IN_ALU_MUL_x SHALL be voted only when OPCODE=010. For any other opcode, OUT_RESULT_MUL SHALL load 0 and the MUL lanes SHALL be excluded from fault comparison.
REQ-027 IN_COUT_x SHALL be voted and compared for every opcode.
REQ-028 FAULT_LANE[i-1] SHALL be set when any compared bit of lane i differs from the voted value. It SHALL be registered with the result and stay valid while OUT_VALID=1.
REQ-029 FAULT_UNCORR SHALL indicate that no whole-word majority exists. The bitwise-voted word is still output in that case.
REQ-030 Fault flags and OPCODE SHALL update only on accept.

Reset
REQ-031 While RST_N=0 at a rising edge, the following SHALL clear to 0: state (EMPTY), OUT_VALID, OUT_RESULT, OUT_RESULT_MUL, OUT_COUT, OUT_OPCODE, FAULT_LANE, FAULT_UNCORR, and all FAULT_CNT.
REQ-032 Reset SHALL take priority over accept and drain. A held result is discarded on reset mid-operation.
REQ-033 Inputs presented during reset SHALL NOT be accepted. IN_READY SHALL read 1 after reset.

Configuration
REQ-034 Macro FAULT_CNT_EN defined: FAULT_CNT_x SHALL exist and behave as follows.
- Increment by 1 on each accept where FAULT_LANE[x-1] is set.
- Saturate at 255.
- CLR_CNT clears to 0 and wins over a simultaneous increment.
REQ-035 FAULT_CNT_EN undefined: the FAULT_CNT_x ports and counters SHALL be absent. CLR_CNT SHALL remain as an ignored input.

Verification
REQ-036 All lanes 16'h1234, COUT 0, OPCODE 000, DataReady=1, OUT_READY=1 -> next cycle OUT_VALID=1, OUT_RESULT=16'h1234, FAULT_LANE=000, FAULT_UNCORR=0.
REQ-037 Lanes 16'h00FF/16'h00FF/16'h80FF, OPCODE 110 -> OUT_RESULT=16'h00FF, FAULT_LANE=100, FAULT_UNCORR=0. With FAULT_CNT_EN: FAULT_CNT_3=1.
REQ-038 OPCODE 010, low words all 16'h0004, MUL lanes 15'h0001/15'h0001/15'h0000 -> OUT_RESULT_MUL=15'h0001, FAULT_LANE=100. Same MUL mismatch with OPCODE 011 -> OUT_RESULT_MUL=0, FAULT_LANE=000.
REQ-039 Lanes 16'h0001/16'h0002/16'h0004 -> OUT_RESULT=16'h0000, FAULT_LANE=111, FAULT_UNCORR=1.
REQ-040 Back-to-back:
- Hold OUT_READY=0 for 3 cycles with DataReady=1 -> the first result holds and IN_READY=0.
- Then raise OUT_READY -> the second result loads the same cycle the first drains.
- Assert RST_N=0 while FULL -> OUT_VALID=0 next edge.
REQ-041 FAULT_CNT_EN: 300 lane-1 faults -> FAULT_CNT_1=255. CLR_CNT asserted together with a fault -> FAULT_CNT_1=0.
